// File: rtl/fir_stim_if.sv
// Paired latency-insensitive channels (valid channel + data channel) feeding the FIR cascade.
interface fir_stim_if #(
    parameter int unsigned DATA_W = 16
);
    logic              o_valid_valid;
    logic              o_valid_data;
    logic              o_valid_stop;
    logic              o_data_valid;
    logic [DATA_W-1:0] o_data_data;
    logic              o_data_stop;

    modport master (
        output o_valid_valid, o_valid_data, o_data_valid, o_data_data,
        input  o_valid_stop, o_data_stop
    );

    modport slave (
        input  o_valid_valid, o_valid_data, o_data_valid, o_data_data,
        output o_valid_stop, o_data_stop
    );
endinterface

// File: rtl/fir_stim_source.sv
// Stimulus transmitter for the FIR cascade: SIM_LEN delta/step (or LFSR) samples, then idle tokens.
// Define FIR_STIM_LFSR_EN to build the LFSR and let rand_sel choose random samples.
module fir_stim_source #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SIM_LEN   = 200,
    parameter int unsigned AMPL      = 20000,
    parameter int unsigned DELTA_IDX = 60,
    parameter int unsigned STEP_IDX  = 120,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rand_sel,
    fir_stim_if.master        bus,
    output logic              done,
    output logic [15:0]       sample_count
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic             vs;
    logic             ds;
    logic             start_pend;

    logic              v_xfer_c;
    logic              d_xfer_c;
    logic              vs_next_c;
    logic              ds_next_c;
    logic              pair_done_c;
    logic              run_enter_c;
    logic [DATA_W-1:0] start_sample_c;
    logic [DATA_W-1:0] next_sample_c;

    function automatic logic [DATA_W-1:0] pattern_sample(input logic [CNT_W-1:0] i);
        if ((i == CNT_W'(DELTA_IDX)) || (i >= CNT_W'(STEP_IDX)))
            return DATA_W'(AMPL);
        return '0;
    endfunction

    assign v_xfer_c    = bus.o_valid_valid & ~bus.o_valid_stop;
    assign d_xfer_c    = bus.o_data_valid & ~bus.o_data_stop;
    assign vs_next_c   = vs | v_xfer_c;
    assign ds_next_c   = ds | d_xfer_c;
    assign pair_done_c = (state == RUN) & vs_next_c & ds_next_c;
    // A run may only begin from DONE on an edge where both idle tokens leave together
    assign run_enter_c = ((state == IDLE) & start) |
                         ((state == DONE) & (start | start_pend) & v_xfer_c & d_xfer_c);

`ifdef FIR_STIM_LFSR_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_step_c;
    logic        rand_mode;
    logic        rand_pend;
    logic        start_rand_c;

    function automatic logic [DATA_W-1:0] rand_sample(input logic [15:0] l);
        logic [15:0] v;
        v = {1'b0, l[14:0]};
        if (v > 16'(AMPL))
            v = v - 16'(AMPL + 1);
        return DATA_W'(v);
    endfunction

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
    assign lfsr_step_c    = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign start_rand_c   = ((state == DONE) && !start) ? rand_pend : rand_sel;
    assign start_sample_c = start_rand_c ? rand_sample(LFSR_SEED) : pattern_sample('0);
    assign next_sample_c  = rand_mode ? rand_sample(lfsr_step_c)
                                      : pattern_sample(idx + CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr      <= LFSR_SEED;
            rand_mode <= 1'b0;
            rand_pend <= 1'b0;
        end else begin
            if ((state == DONE) && start)
                rand_pend <= rand_sel;
            if (run_enter_c) begin
                lfsr      <= LFSR_SEED;
                rand_mode <= start_rand_c;
            end else if (pair_done_c) begin
                lfsr <= lfsr_step_c;
            end
        end
    end
`else
    logic unused_rand_sel;
    assign unused_rand_sel = rand_sel;
    assign start_sample_c  = pattern_sample('0);
    assign next_sample_c   = pattern_sample(idx + CNT_W'(1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            idx               <= '0;
            vs                <= 1'b0;
            ds                <= 1'b0;
            start_pend        <= 1'b0;
            bus.o_valid_valid <= 1'b0;
            bus.o_valid_data  <= 1'b0;
            bus.o_data_valid  <= 1'b0;
            bus.o_data_data   <= '0;
            done              <= 1'b0;
            sample_count      <= '0;
        end else if (run_enter_c) begin
            state             <= RUN;
            idx               <= '0;
            vs                <= 1'b0;
            ds                <= 1'b0;
            start_pend        <= 1'b0;
            bus.o_valid_valid <= 1'b1;
            bus.o_valid_data  <= 1'b1;
            bus.o_data_valid  <= 1'b1;
            bus.o_data_data   <= start_sample_c;
            done              <= 1'b0;
            sample_count      <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (pair_done_c) begin
                        vs                <= 1'b0;
                        ds                <= 1'b0;
                        sample_count      <= sample_count + 16'd1;
                        bus.o_valid_valid <= 1'b1;
                        bus.o_data_valid  <= 1'b1;
                        if (idx == CNT_W'(SIM_LEN - 1)) begin
                            state            <= DONE;
                            done             <= 1'b1;
                            bus.o_valid_data <= 1'b0;
                            bus.o_data_data  <= '0;
                        end else begin
                            idx              <= idx + CNT_W'(1);
                            bus.o_valid_data <= 1'b1;
                            bus.o_data_data  <= next_sample_c;
                        end
                    end else begin
                        // A channel that already delivered sample idx idles until its partner catches up
                        vs                <= vs_next_c;
                        ds                <= ds_next_c;
                        bus.o_valid_valid <= ~vs_next_c;
                        bus.o_data_valid  <= ~ds_next_c;
                    end
                end
                DONE: begin
                    if (start)
                        start_pend <= 1'b1;
                end
                IDLE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_stim_source.sv
// Scoreboard bench for fir_stim_source: directed runs push expected tokens, a negedge monitor pops them.
module tb_fir_stim_source;
    logic        clk;
    logic        reset;
    logic        start;
    logic        rand_sel;
    logic        done;
    logic [15:0] sample_count;

    int checks   = 0;
    int failures = 0;

`ifdef FIR_STIM_LFSR_EN
    localparam bit LFSR_EN = 1'b1;
`else
    localparam bit LFSR_EN = 1'b0;
`endif

    fir_stim_if #(.DATA_W(16)) bus ();

    fir_stim_source dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rand_sel     (rand_sel),
        .bus          (bus),
        .done         (done),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit          exp_v_q[$];
    logic [15:0] exp_d_q[$];
    int          n_v_real = 0;
    int          n_d_pop  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected run: delta at 60, step from 120 at 20000; or the seeded LFSR reference
    task automatic push_run(input bit rnd);
        int st;
        int v;
        st = 'hACE1;
        for (int i = 0; i < 200; i++) begin
            if (rnd && LFSR_EN) begin
                v  = st % 32768;
                if (v > 20000) v = v - 20001;
                st = (st / 2) + (((st ^ (st >> 2) ^ (st >> 3) ^ (st >> 5)) & 1) * 32768);
            end else begin
                v = ((i == 60) || (i >= 120)) ? 20000 : 0;
            end
            exp_v_q.push_back(1'b1);
            exp_d_q.push_back(16'(v));
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    // Monitor: each transfer pops the next expected token; an empty queue means an idle token
    bit          ev;
    logic [15:0] ed;
    bit          d_stalled = 1'b0;
    logic [15:0] d_held    = '0;
    always @(negedge clk) begin
        if (reset) begin
            d_stalled = 1'b0;
        end else begin
            if (bus.o_valid_valid && !bus.o_valid_stop) begin
                if (exp_v_q.size() != 0) ev = exp_v_q.pop_front();
                else ev = 1'b0;
                chk("valid_ch_payload", 32'(bus.o_valid_data), 32'(ev));
                if (bus.o_valid_data) n_v_real++;
            end
            if (d_stalled && bus.o_data_valid)
                chk("data_ch_hold", 32'(bus.o_data_data), 32'(d_held));
            if (bus.o_data_valid && !bus.o_data_stop) begin
                if (exp_d_q.size() != 0) begin
                    ed = exp_d_q.pop_front();
                    n_d_pop++;
                end else begin
                    ed = '0;
                end
                chk("data_ch_payload", 32'(bus.o_data_data), 32'(ed));
            end
            d_stalled = bus.o_data_valid && bus.o_data_stop;
            d_held    = bus.o_data_data;
        end
    end

    initial begin
        int base_v;
        int base_d;
        int n;

        reset = 1'b1;
        start = 1'b0;
        rand_sel = 1'b0;
        bus.o_valid_stop = 1'b0;
        bus.o_data_stop  = 1'b0;
        repeat (2) tick();
        chk("rst_valid_valid", 32'(bus.o_valid_valid), 32'd0);
        chk("rst_data_valid",  32'(bus.o_data_valid),  32'd0);
        chk("rst_valid_data",  32'(bus.o_valid_data),  32'd0);
        chk("rst_data_data",   32'(bus.o_data_data),   32'd0);
        chk("rst_done",        32'(done),              32'd0);
        chk("rst_count",       32'(sample_count),      32'd0);
        reset = 1'b0;
        tick();

        // Pattern run, no backpressure
        base_v = n_v_real;
        start = 1'b1;
        tick();
        start = 1'b0;
        push_run(1'b0);
        chk("lat_valid_valid", 32'(bus.o_valid_valid), 32'd1);
        chk("lat_data_valid",  32'(bus.o_data_valid),  32'd1);
        chk("lat_valid_data",  32'(bus.o_valid_data),  32'd1);
        repeat (199) tick();
        chk("done_not_early", 32'(done), 32'd0);
        tick();
        chk("done_on_time",   32'(done),         32'd1);
        chk("count_run1",     32'(sample_count), 32'd200);
        chk("idle_token",     32'(bus.o_valid_data),  32'd0);
        chk("idle_valid",     32'(bus.o_valid_valid), 32'd1);
        repeat (5) tick();
        chk("run1_samples", 32'(n_v_real - base_v), 32'd200);

        // Data-channel stall while sample 10 is presented
        base_v = n_v_real;
        start = 1'b1;
        tick();
        start = 1'b0;
        push_run(1'b0);
        chk("restart_done_clr", 32'(done), 32'd0);
        repeat (10) tick();
        bus.o_data_stop = 1'b1;
        tick();
        chk("stall_valid_drop", 32'(bus.o_valid_valid), 32'd0);
        chk("stall_data_valid", 32'(bus.o_data_valid),  32'd1);
        chk("stall_count",      32'(sample_count),      32'd10);
        repeat (4) tick();
        chk("stall_valid_low",  32'(bus.o_valid_valid), 32'd0);
        bus.o_data_stop = 1'b0;
        tick();
        chk("resume_valid_valid", 32'(bus.o_valid_valid), 32'd1);
        chk("resume_data_valid",  32'(bus.o_data_valid),  32'd1);
        chk("resume_count",       32'(sample_count),      32'd11);
        wait_done(400);
        chk("run2_samples", 32'(n_v_real - base_v), 32'd200);

        // Alternating backpressure on the two channels
        base_v = n_v_real;
        base_d = n_d_pop;
        start = 1'b1;
        tick();
        start = 1'b0;
        push_run(1'b0);
        n = 0;
        while (!done && n < 2000) begin
            bus.o_valid_stop = (n % 2) == 0;
            bus.o_data_stop  = (n % 2) == 1;
            tick();
            n++;
        end
        bus.o_valid_stop = 1'b0;
        bus.o_data_stop  = 1'b0;
        chk("alt_done",          32'(done),              32'd1);
        chk("alt_count",         32'(sample_count),      32'd200);
        chk("alt_valid_samples", 32'(n_v_real - base_v), 32'd200);
        chk("alt_data_samples",  32'(n_d_pop - base_d),  32'd200);
        repeat (3) tick();

        // Random-select run aborted by reset at sample 87
        rand_sel = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        rand_sel = 1'b0;
        push_run(1'b1);
        n = 0;
        while (sample_count != 16'd87 && n < 400) begin
            tick();
            n++;
        end
        chk("reach_87", 32'(sample_count), 32'd87);
        reset = 1'b1;
        bus.o_valid_stop = 1'b1;
        bus.o_data_stop  = 1'b1;
        tick();
        chk("midrst_valid_valid", 32'(bus.o_valid_valid), 32'd0);
        chk("midrst_data_valid",  32'(bus.o_data_valid),  32'd0);
        chk("midrst_data_data",   32'(bus.o_data_data),   32'd0);
        chk("midrst_count",       32'(sample_count),      32'd0);
        chk("midrst_done",        32'(done),              32'd0);
        exp_v_q.delete();
        exp_d_q.delete();
        reset = 1'b0;
        bus.o_valid_stop = 1'b0;
        bus.o_data_stop  = 1'b0;
        tick();

        // Random-select run from IDLE, then identical rerun from DONE
        base_v = n_v_real;
        rand_sel = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        rand_sel = 1'b0;
        push_run(1'b1);
        wait_done(400);
        chk("rand1_samples", 32'(n_v_real - base_v), 32'd200);
        base_v = n_v_real;
        rand_sel = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        rand_sel = 1'b0;
        push_run(1'b1);
        wait_done(400);
        chk("rand2_samples", 32'(n_v_real - base_v), 32'd200);
        repeat (2) tick();

        // Start pulsed in DONE while the valid channel is stopped
        bus.o_valid_stop = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("pend_done",       32'(done),              32'd1);
            chk("pend_idle_token", 32'(bus.o_valid_data),  32'd0);
            chk("pend_valid",      32'(bus.o_valid_valid), 32'd1);
            tick();
        end
        base_v = n_v_real;
        bus.o_valid_stop = 1'b0;
        tick();
        push_run(1'b0);
        chk("pend_enter_done",  32'(done),             32'd0);
        chk("pend_enter_count", 32'(sample_count),     32'd0);
        chk("pend_enter_real",  32'(bus.o_valid_data), 32'd1);
        wait_done(400);
        repeat (3) tick();
        chk("pend_samples",  32'(n_v_real - base_v), 32'd200);
        chk("queue_drained", 32'(exp_v_q.size() + exp_d_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
